// File: rtl/gpio_wbarb_pkg.sv
// Shared definitions for the GPIO Wishbone arbiter: FSM encoding and the
// masked-write data word layout understood by the GPIO peripheral.
package gpio_wbarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  localparam int MASK_LSB = 16;
  localparam int VAL_LSB  = 0;
  localparam int WB_DW    = 32;

endpackage

// File: rtl/gpio_wbarb_rr_pick.sv
// Round-robin priority search: first asserted request at or after ptr,
// wrapping cyclically over NREQ entries.
module gpio_wbarb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int          k;
    logic [PW-1:0] kk;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    kk    = '0;
    // Scan from the farthest offset down so the nearest hit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = PW'(k);
      if (req[kk]) begin
        found = 1'b1;
        idx   = kk;
      end
    end
  end

endmodule

// File: rtl/gpio_wbarb.sv
// Round-robin arbiter serialising per-requester set/clear masks into
// masked Wishbone writes to the single GPIO output register.
module gpio_wbarb
  import gpio_wbarb_pkg::*;
#(
  parameter int            NREQ      = 4,
  parameter int            NOUT      = 16,
  parameter int            AW        = 30,
  parameter logic [AW-1:0] GPIO_ADDR = '0,
  parameter int            TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_areset_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*NOUT-1:0] i_mask,
  input  logic [NREQ*NOUT-1:0] i_val,
  output logic [NREQ-1:0]      o_done,
  output logic [NREQ-1:0]      o_err,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [AW-1:0]        o_wb_addr,
  output logic [WB_DW-1:0]     o_wb_data,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state, state_d;
  logic [PW-1:0]     rr_ptr, gnt, pick_idx;
  logic              pick_found;
  logic [NREQ-1:0]   req_elig;
  logic [CW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic [WB_DW-1:0]  wb_data, wb_word;
  logic [NOUT-1:0]   pick_mask, pick_val;
  logic              fin_pend, fin_err;
  logic [NREQ-1:0]   done_r, err_r;
  logic              do_grant, do_fin, fin_is_err;

  // The requester just served still holds i_req until it sees its pulse,
  // so keep it out of arbitration until that pulse has been delivered.
  always_comb begin
    req_elig = i_req;
    if (fin_pend || (|done_r) || (|err_r)) req_elig[gnt] = 1'b0;
  end

  gpio_wbarb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req_elig),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_mask = i_mask[pick_idx*NOUT +: NOUT];
    pick_val  = i_val[pick_idx*NOUT +: NOUT];
    wb_word   = '0;
    wb_word[MASK_LSB +: NOUT] = pick_mask;
    wb_word[VAL_LSB +: NOUT]  = pick_val & pick_mask;
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_fin     = 1'b0;
    fin_is_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          do_grant = 1'b1;
          state_d  = ST_STROBE;
        end
      end
      ST_STROBE, ST_WAIT: begin
        if (i_wb_ack || i_wb_err) begin
          do_fin     = 1'b1;
          fin_is_err = i_wb_err;
          state_d    = ST_IDLE;
        end else if (tmo_hit) begin
          do_fin     = 1'b1;
          fin_is_err = 1'b1;
          state_d    = ST_IDLE;
        end else if ((state == ST_STROBE) && !i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) state <= ST_IDLE;
    else             state <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rr_ptr   <= '0;
      gnt      <= '0;
      tmo_cnt  <= '0;
      wb_data  <= '0;
      fin_pend <= 1'b0;
      fin_err  <= 1'b0;
      done_r   <= '0;
      err_r    <= '0;
    end else begin
      fin_pend <= do_fin;
      fin_err  <= fin_is_err;
      done_r   <= '0;
      err_r    <= '0;
      if (fin_pend) begin
        if (fin_err) err_r[gnt]  <= 1'b1;
        else         done_r[gnt] <= 1'b1;
      end
      if (do_grant) begin
        gnt     <= pick_idx;
        rr_ptr  <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        tmo_cnt <= '0;
        wb_data <= wb_word;
      end else if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign o_wb_cyc  = (state != ST_IDLE);
  assign o_wb_stb  = (state == ST_STROBE);
  assign o_wb_we   = 1'b1;
  assign o_wb_addr = GPIO_ADDR;
  assign o_wb_data = wb_data;
  assign o_done    = done_r;
  assign o_err     = err_r;

endmodule

// File: tb/tb_gpio_wbarb.sv
// Directed bench for gpio_wbarb with a small Wishbone GPIO slave model.
module tb_gpio_wbarb;

  localparam int            NREQ      = 4;
  localparam int            NOUT      = 16;
  localparam int            AW        = 30;
  localparam int            TIMEOUT   = 8;
  localparam logic [AW-1:0] GPIO_ADDR = 30'h123;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*NOUT-1:0] mask = '0;
  logic [NREQ*NOUT-1:0] val = '0;
  logic [NREQ-1:0]      done, errv;
  logic                 cyc, stb, we;
  logic [AW-1:0]        addr;
  logic [31:0]          data;
  logic                 stall, ack_in, err_in;

  int checks = 0;
  int failures = 0;

  int          stall_cfg = 0;
  int          stall_cnt = 0;
  logic        noresp = 1'b0;
  logic        err_en = 1'b0;
  logic [15:0] err_mask = 16'h0;
  logic        ack_r = 1'b0, err_r = 1'b0, force_ack = 1'b0;
  logic [15:0] gpio = 16'h0;
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;
  logic        addr_bad = 1'b0;
  logic        viol = 1'b0;
  int          ncyc = 0;

  gpio_wbarb #(
    .NREQ(NREQ), .NOUT(NOUT), .AW(AW), .GPIO_ADDR(GPIO_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_req(req), .i_mask(mask), .i_val(val),
    .o_done(done), .o_err(errv), .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
    .o_wb_addr(addr), .o_wb_data(data), .i_wb_stall(stall), .i_wb_ack(ack_in),
    .i_wb_err(err_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  // GPIO slave: optional stall, then ack/err one cycle after acceptance.
  assign stall  = cyc && stb && (stall_cnt != 0);
  assign ack_in = ack_r | force_ack;
  assign err_in = err_r;

  always @(posedge clk) begin
    ack_r <= 1'b0;
    err_r <= 1'b0;
    if (!(cyc && stb)) begin
      stall_cnt <= stall_cfg;
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
    end else begin
      if (wr_cnt < 64) wr_data[wr_cnt] <= data;
      wr_cnt <= wr_cnt + 1;
      if (addr !== GPIO_ADDR || we !== 1'b1) addr_bad <= 1'b1;
      if (!noresp) begin
        if (err_en && data[31:16] == err_mask) err_r <= 1'b1;
        else begin
          ack_r <= 1'b1;
          gpio  <= (gpio & ~data[31:16]) | (data[15:0] & data[31:16]);
        end
      end
    end
  end

  always @(negedge clk)
    if (((done & errv) != 0) || !$onehot0(done) || !$onehot0(errv)) viol <= 1'b1;

  task automatic set_req(input int k, input logic [15:0] m, input logic [15:0] v);
    req[k] = 1'b1;
    mask[k*NOUT +: NOUT] = m;
    val[k*NOUT +: NOUT]  = v;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] x);
    int r;
    r = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (x[i]) r = i;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cyc !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%0b exp=0", cyc); end
    checks++; if (stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%0b exp=0", stb); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL reset_we got=%0b exp=1", we); end
    checks++; if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (done !== 4'h0 || errv !== 4'h0) begin failures++; $display("FAIL reset_pulses got=%b/%b exp=0000/0000", done, errv); end
    checks++; if (addr !== GPIO_ADDR) begin failures++; $display("FAIL reset_addr got=%h exp=%h", addr, GPIO_ADDR); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cyc !== 1'b0) begin failures++; $display("FAIL idle_cyc got=%0b exp=0", cyc); end
  endtask

  task automatic test_single();
    int base;
    base = wr_cnt;
    @(negedge clk); set_req(0, 16'h0001, 16'h0001);
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || stb !== 1'b1) begin failures++; $display("FAIL single_grant got=%0b%0b exp=11", cyc, stb); end
    checks++; if (data !== 32'h00010001) begin failures++; $display("FAIL single_data got=%h exp=00010001", data); end
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || stb !== 1'b0) begin failures++; $display("FAIL single_wait got=%0b%0b exp=10", cyc, stb); end
    @(negedge clk);
    checks++; if (cyc !== 1'b0 || done !== 4'h0) begin failures++; $display("FAIL single_drop got=%0b/%b exp=0/0000", cyc, done); end
    @(negedge clk);
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", done); end
    req[0] = 1'b0;
    @(negedge clk);
    checks++; if (done !== 4'h0) begin failures++; $display("FAIL single_pulse_len got=%b exp=0000", done); end
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt - base !== 1) begin failures++; $display("FAIL single_writes got=%0d exp=1", wr_cnt - base); end
    checks++; if (gpio !== 16'h0001) begin failures++; $display("FAIL single_gpio got=%h exp=0001", gpio); end
  endtask

  task automatic test_contention();
    int base, n;
    int ord [5];
    int tm [5];
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_dat [5] = '{32'h00010001, 32'h00020000, 32'h00040004, 32'h00080000, 32'h00100010};
    bit first0;
    pulse_reset();
    base = wr_cnt; n = 0; first0 = 1'b1;
    for (int i = 0; i < 5; i++) begin ord[i] = -1; tm[i] = 0; end
    @(negedge clk);
    set_req(0, 16'h0001, 16'h0001); set_req(1, 16'h0002, 16'h0000);
    set_req(2, 16'h0004, 16'h0004); set_req(3, 16'h0008, 16'h0000);
    for (int c = 0; c < 80 && n < 5; c++) begin
      @(negedge clk);
      if (done != 0) begin
        int k;
        k = onehot_idx(done);
        ord[n] = k; tm[n] = ncyc; n++;
        if (k == 0 && first0) begin first0 = 1'b0; set_req(0, 16'h0010, 16'h0010); end
        else if (k >= 0) req[k] = 1'b0;
      end
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL cont_count got=%0d exp=5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ord[i] !== exp_ord[i]) begin failures++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, ord[i], exp_ord[i]); end
      checks++; if (wr_data[base+i] !== exp_dat[i]) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, wr_data[base+i], exp_dat[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      checks++; if (tm[i] - tm[i-1] !== 3) begin failures++; $display("FAIL cont_gap[%0d] got=%0d exp=3", i, tm[i] - tm[i-1]); end
    end
    checks++; if (gpio !== 16'h0015) begin failures++; $display("FAIL cont_gpio got=%h exp=0015", gpio); end
  endtask

  task automatic test_stall();
    int stb_n, bad, dn;
    logic [NREQ-1:0] dv;
    stb_n = 0; bad = 0; dn = 0; dv = '0;
    stall_cfg = 5;
    @(negedge clk); set_req(1, 16'h00F0, 16'h00A0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stb) begin
        stb_n++;
        if (data !== 32'h00F000A0) bad++;
      end
      if (done != 0) begin dn++; dv = done; req[1] = 1'b0; end
    end
    stall_cfg = 0;
    checks++; if (stb_n !== 6) begin failures++; $display("FAIL stall_stb_len got=%0d exp=6", stb_n); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_data_stable got=%0d exp=0", bad); end
    checks++; if (dn !== 1 || dv !== 4'b0010) begin failures++; $display("FAIL stall_done got=%0d/%b exp=1/0010", dn, dv); end
    checks++; if (gpio !== 16'h00A5) begin failures++; $display("FAIL stall_gpio got=%h exp=00a5", gpio); end
  endtask

  task automatic test_error();
    int ne;
    bit ev_err [2];
    logic [NREQ-1:0] ev_vec [2];
    ne = 0;
    for (int i = 0; i < 2; i++) begin ev_err[i] = 1'b0; ev_vec[i] = '0; end
    err_en = 1'b1; err_mask = 16'h0100;
    @(negedge clk); set_req(2, 16'h0100, 16'h0100); set_req(3, 16'h0200, 16'h0200);
    for (int c = 0; c < 40 && ne < 2; c++) begin
      @(negedge clk);
      if (errv != 0) begin
        ev_err[ne] = 1'b1; ev_vec[ne] = errv; ne++;
        if (onehot_idx(errv) >= 0) req[onehot_idx(errv)] = 1'b0;
      end else if (done != 0) begin
        ev_err[ne] = 1'b0; ev_vec[ne] = done; ne++;
        if (onehot_idx(done) >= 0) req[onehot_idx(done)] = 1'b0;
      end
    end
    err_en = 1'b0;
    checks++; if (ne !== 2) begin failures++; $display("FAIL err_events got=%0d exp=2", ne); end
    checks++; if (ev_err[0] !== 1'b1 || ev_vec[0] !== 4'b0100) begin failures++; $display("FAIL err_first got=err%0b/%b exp=err1/0100", ev_err[0], ev_vec[0]); end
    checks++; if (ev_err[1] !== 1'b0 || ev_vec[1] !== 4'b1000) begin failures++; $display("FAIL err_next got=err%0b/%b exp=err0/1000", ev_err[1], ev_vec[1]); end
    checks++; if (gpio !== 16'h02A5) begin failures++; $display("FAIL err_gpio got=%h exp=02a5", gpio); end
  endtask

  task automatic test_timeout();
    int hi, quiet;
    hi = 0; quiet = 0;
    noresp = 1'b1;
    @(negedge clk); set_req(0, 16'h8000, 16'h8000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cyc) hi++;
      else break;
    end
    checks++; if (hi !== TIMEOUT) begin failures++; $display("FAIL tmo_cyc_len got=%0d exp=%0d", hi, TIMEOUT); end
    checks++; if (errv !== 4'h0) begin failures++; $display("FAIL tmo_err_early got=%b exp=0000", errv); end
    @(negedge clk);
    checks++; if (errv !== 4'b0001 || done !== 4'h0) begin failures++; $display("FAIL tmo_err got=%b/%b exp=0001/0000", errv, done); end
    req[0] = 1'b0;
    noresp = 1'b0;
    @(negedge clk); force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 0 || errv != 0 || cyc) quiet++;
    end
    checks++; if (quiet !== 0) begin failures++; $display("FAIL tmo_late_ack got=%0d exp=0", quiet); end
    checks++; if (gpio !== 16'h02A5) begin failures++; $display("FAIL tmo_gpio got=%h exp=02a5", gpio); end
  endtask

  task automatic test_reset_mid();
    int base, pulses;
    logic [NREQ-1:0] dv;
    base = wr_cnt; pulses = 0; dv = '0;
    noresp = 1'b1;
    @(negedge clk); set_req(1, 16'h0002, 16'h0002);
    repeat (3) @(negedge clk);
    checks++; if (cyc !== 1'b1 || stb !== 1'b0) begin failures++; $display("FAIL rstmid_wait got=%0b%0b exp=10", cyc, stb); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%0b%0b exp=00", cyc, stb); end
    repeat (3) begin
      @(negedge clk);
      if (done != 0 || errv != 0) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
    noresp = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done != 0 || errv != 0) begin dv = done | errv; req[1] = 1'b0; break; end
    end
    checks++; if (dv !== 4'b0010 || errv !== 4'h0) begin failures++; $display("FAIL rstmid_done got=%b err=%b exp=0010/0000", dv, errv); end
    checks++; if (wr_cnt - base !== 2) begin failures++; $display("FAIL rstmid_writes got=%0d exp=2", wr_cnt - base); end
    checks++; if (wr_data[base+1] !== 32'h00020002) begin failures++; $display("FAIL rstmid_data got=%h exp=00020002", wr_data[base+1]); end
    checks++; if (gpio !== 16'h02A7) begin failures++; $display("FAIL rstmid_gpio got=%h exp=02a7", gpio); end
  endtask

  task automatic test_bus_rules();
    repeat (2) @(negedge clk);
    checks++; if (viol !== 1'b0) begin failures++; $display("FAIL pulse_rules got=%0b exp=0", viol); end
    checks++; if (addr_bad !== 1'b0) begin failures++; $display("FAIL bus_addr_we got=%0b exp=0", addr_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_error();
    test_timeout();
    test_reset_mid();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
